poly_crc_checker: RTL and testbench
===================================

# poly_crc_checker

Receive-side CRC checker for the polymorphic CRC subsystem. It accepts a byte stream over a valid/ready handshake, computes a CRC over a programmed number of payload bytes, and captures the appended CRC bytes. It then reports pass or fail. The polynomial is selected per frame by `orient`, mirroring the generator's polymorphic polynomial select, so frames produced under either orientation are checked by this one block.

## Interface

Parameters:
- `CRC_W`, default 16: CRC width in bits; must be a multiple of 8.
- `POLY_A`, default 16'h1021: polynomial used when `orient`=0.
- `POLY_B`, default 16'h8005: polynomial used when `orient`=1.
- `INIT`, default 16'hFFFF: CRC register seed at frame start.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle frame start request.
- `orient`  in  1  polynomial select, sampled with `start`.
- `frame_len`  in  16  payload byte count, sampled with `start`; 0 is legal.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when the verdict is final.
- `pass`  out  1  received CRC equals computed CRC.
- `crc_out`  out  CRC_W  computed CRC of the last frame.

## Operation

- FSM states: IDLE, DATA, CRC, DONE.
- IDLE:
  - `in_ready`=0, `busy`=0.
  - On `start`: latch `orient` and `frame_len`, set crc<=INIT, clear the receive shift register and byte counter.
  - Go to DATA if `frame_len`>0, else go to CRC.
- DATA:
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) updates crc with the byte: MSB-first, non-reflected, 8 bit-steps per cycle, no final XOR.
  - Step rule: fb=crc[CRC_W-1]^bit; crc=(crc<<1)^(fb?POLY:0).
  - After the `frame_len`-th byte, go to CRC.
- CRC:
  - `in_ready`=1.
  - Accept CRC_W/8 bytes, MSB byte first, into the receive shift register. These bytes do not update crc.
  - After the last byte, go to DONE.
- DONE:
  - `done`=1 for exactly this one cycle.
  - `pass` and `crc_out` are registered here and held until the next accepted `start` or `RST`.
  - Next state: IDLE.
- `start` while `busy`=1 is ignored. Frame parameters are unchanged.
- `in_valid` in IDLE or DONE is ignored; no byte is consumed.
- `in_ready` depends only on state, never on `in_valid`.
- The byte counter is 16 bits. `frame_len`=16'hFFFF is accepted without wrap.
- Accepting a new `start` clears `pass` to 0; `crc_out` retains its old value until DONE.

## Timing

- Reset values: `in_ready`=0, `busy`=0, `done`=0, `pass`=0, `crc_out`=0. FSM goes to IDLE and internal crc goes to INIT.
- `RST` asserted mid-frame aborts the frame on the next edge. No `done` is issued.
- `start` at edge t puts the FSM in DATA/CRC at t+1; `in_ready` and `busy` are high from t+1.
- The last CRC byte handshake at edge t gives DONE with `done`=1 during t+1. The block is IDLE at t+2 and can accept `start` in cycle t+2.
- Minimum frame time at full throughput: 1 + `frame_len` + CRC_W/8 + 1 cycles, start to done.
- A stalled `in_valid` holds state indefinitely. There is no timeout.
- `start` asserted in the DONE cycle is ignored, because `busy`=1 in DONE.

## Test plan

- Reset then idle: assert `RST` 2 cycles -> all outputs 0. `in_valid`=1 with random data for 10 cycles -> `in_ready`=0, no `done`.
- Orient 0, ASCII "123456789" (`frame_len`=9), then CRC bytes 29,B1 -> `crc_out`=16'h29B1, `pass`=1, `done` one cycle after the last byte.
- Orient 1, same payload, then bytes AE,E7 -> `crc_out`=16'hAEE7, `pass`=1. Repeat with AE,E6 -> `pass`=0, `crc_out`=16'hAEE7.
- `frame_len`=0, orient 0, bytes FF,FF -> `pass`=1, `crc_out`=16'hFFFF. Bytes 00,00 -> `pass`=0.
- Backpressure and abuse: single payload byte 00 (orient 0) with `in_valid` toggled randomly, plus `start` pulsed mid-frame with `frame_len`=5 -> frame unaffected, `crc_out`=16'hE1F0, `pass`=1 for bytes E1,F0.
- Reset mid-frame: `RST` after 4 of 9 payload bytes -> next cycle `busy`=0, no `done`. A fresh "123456789" frame afterward passes with 29,B1.

Source files
------------

// File: rtl/poly_crc_checker.sv
// Receive-side CRC checker: hashes frame_len payload bytes with a per-frame
// selectable polynomial, captures the appended CRC bytes and reports pass/fail.
module poly_crc_checker #(
    parameter int                 CRC_W  = 16,
    parameter logic [CRC_W-1:0]   POLY_A = 16'h1021,
    parameter logic [CRC_W-1:0]   POLY_B = 16'h8005,
    parameter logic [CRC_W-1:0]   INIT   = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             orient,
    input  logic [15:0]      frame_len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CRC_W-1:0] crc_out
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_DATA  = 2'd1;
    localparam logic [1:0]  S_CRC   = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;
    localparam int          NB      = CRC_W / 8;
    localparam logic [15:0] NB_LAST = 16'(NB - 1);

    // MSB-first, non-reflected update of the CRC register by one whole byte.
    function automatic logic [CRC_W-1:0] crc_byte(
        input logic [CRC_W-1:0] crc_in,
        input logic [7:0]       byte_in,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ byte_in[i];
            c  = (c << 1) ^ (fb ? poly : {CRC_W{1'b0}});
        end
        return c;
    endfunction

    logic [1:0]       state_q,    state_d;
    logic [CRC_W-1:0] crc_q,      crc_d;
    logic [CRC_W-1:0] rx_q,       rx_d;
    logic [CRC_W-1:0] crc_out_q,  crc_out_d;
    logic [15:0]      len_q,      len_d;
    logic [15:0]      cnt_q,      cnt_d;
    logic             orient_q,   orient_d;
    logic             pass_q,     pass_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             hs_s;

    assign hs_s = in_valid & in_ready_q;

    // Next-state logic for the frame FSM, CRC accumulator and receive register.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        rx_d      = rx_q;
        crc_out_d = crc_out_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        orient_d  = orient_q;
        pass_d    = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    orient_d = orient;
                    len_d    = frame_len;
                    crc_d    = INIT;
                    rx_d     = {CRC_W{1'b0}};
                    cnt_d    = 16'd0;
                    pass_d   = 1'b0;
                    state_d  = (frame_len != 16'd0) ? S_DATA : S_CRC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_DATA: begin
                if (hs_s) begin
                    crc_d = crc_byte(crc_q, in_data, orient_q ? POLY_B : POLY_A);
                    // Compare against len-1 so a 16'hFFFF length never wraps the counter.
                    if (cnt_q == 16'(len_q - 16'd1)) begin
                        cnt_d   = 16'd0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CRC: begin
                if (hs_s) begin
                    rx_d = (rx_q << 8) | CRC_W'(in_data);
                    if (cnt_q == NB_LAST) begin
                        cnt_d     = 16'd0;
                        pass_d    = (rx_d == crc_q);
                        crc_out_d = crc_q;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d     = cnt_q + 16'd1;
                    end
                end else begin
                    state_d = S_CRC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake/status outputs are decoded from the next state so they stay registered.
    always_comb begin
        in_ready_d = (state_d == S_DATA) || (state_d == S_CRC);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            crc_q      <= INIT;
            rx_q       <= {CRC_W{1'b0}};
            crc_out_q  <= {CRC_W{1'b0}};
            len_q      <= 16'd0;
            cnt_q      <= 16'd0;
            orient_q   <= 1'b0;
            pass_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            rx_q       <= rx_d;
            crc_out_q  <= crc_out_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            orient_q   <= orient_d;
            pass_q     <= pass_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign crc_out  = crc_out_q;

endmodule

// File: tb/tb_poly_crc_checker.sv
// Self-checking bench for poly_crc_checker: directed vectors plus random frames
// checked against a whole-message CRC reference model.
module tb_poly_crc_checker;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        orient;
    logic [15:0] frame_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] crc_out;

    int checks = 0;
    int errors = 0;

    poly_crc_checker dut (
        .CLK(CLK), .RST(RST), .start(start), .orient(orient),
        .frame_len(frame_len), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .crc_out(crc_out)
    );

    always #5 CLK = ~CLK;

    // Reference: CRC of the whole message as one MSB-first bit sequence.
    function automatic logic [15:0] model_crc(input bit o, input logic [7:0] msg[$]);
        int unsigned r;
        int unsigned poly;
        int unsigned top;
        r    = 32'h0000FFFF;
        poly = o ? 32'h00008005 : 32'h00001021;
        for (int k = 0; k < msg.size() * 8; k++) begin
            top = ((r >> 15) & 32'd1) ^ ((msg[k / 8] >> (7 - (k % 8))) & 32'd1);
            r   = (r << 1) & 32'h0000FFFF;
            if (top != 0) r = r ^ poly;
        end
        return r[15:0];
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input bit o, input logic [15:0] len);
        start     = 1'b1;
        orient    = o;
        frame_len = len;
        cyc();
        start     = 1'b0;
        orient    = 1'($urandom);
        frame_len = 16'($urandom);
    endtask

    // Offer one byte until accepted; optionally toggle in_valid randomly.
    task automatic send(input logic [7:0] b, input bit rnd);
        bit accepted;
        int n;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 200) begin
            in_valid = rnd ? 1'($urandom) : 1'b1;
            in_data  = in_valid ? b : 8'($urandom);
            accepted = in_valid && in_ready;
            cyc();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted, got in_ready=%b expected 1", b, in_ready);
        end
    endtask

    task automatic run_frame(input string name, input bit o, input logic [7:0] msg[$],
                             input logic [7:0] c_hi, input logic [7:0] c_lo, input bit rnd,
                             input bit exp_pass, input logic [15:0] exp_crc);
        do_start(o, 16'(msg.size()));
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: got busy=%b in_ready=%b pass=%b expected 1 1 0", name, busy, in_ready, pass);
        end
        foreach (msg[i]) send(msg[i], rnd);
        send(c_hi, rnd);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_done: got done=%b expected 0", name, done);
        end
        send(c_lo, rnd);
        checks++;
        if (done !== 1'b1 || pass !== exp_pass || crc_out !== exp_crc) begin
            errors++;
            $display("FAIL %s_verdict: got done=%b pass=%b crc=%h expected 1 %b %h",
                     name, done, pass, crc_out, exp_pass, exp_crc);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass || crc_out !== exp_crc) begin
            errors++;
            $display("FAIL %s_hold: got done=%b busy=%b pass=%b crc=%h expected 0 0 %b %h",
                     name, done, busy, pass, crc_out, exp_pass, exp_crc);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc();
        cyc();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || crc_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset: got %b%b%b%b crc=%h expected 0000 crc=0000", in_ready, busy, done, pass, crc_out);
        end
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            cyc();
            checks++;
            if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: got in_ready=%b done=%b busy=%b expected 0 0 0", in_ready, done, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] msg[$];
        logic [7:0] empty[$];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        empty = {};
        run_frame("ccitt", 1'b0, msg, 8'h29, 8'hB1, 1'b0, 1'b1, 16'h29B1);
        run_frame("poly8005", 1'b1, msg, 8'hAE, 8'hE7, 1'b0, 1'b1, 16'hAEE7);
        run_frame("poly8005_bad", 1'b1, msg, 8'hAE, 8'hE6, 1'b0, 1'b0, 16'hAEE7);
        run_frame("len0", 1'b0, empty, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFFFF);
        run_frame("len0_bad", 1'b0, empty, 8'h00, 8'h00, 1'b0, 1'b0, 16'hFFFF);
    endtask

    task automatic test_abuse();
        do_start(1'b0, 16'd1);
        send(8'h00, 1'b1);
        // A start while busy must not relaunch the frame.
        start     = 1'b1;
        orient    = 1'b1;
        frame_len = 16'd5;
        cyc();
        start     = 1'b0;
        send(8'hE1, 1'b1);
        send(8'hF0, 1'b1);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || crc_out !== 16'hE1F0) begin
            errors++;
            $display("FAIL abuse: got done=%b pass=%b crc=%h expected 1 1 e1f0", done, pass, crc_out);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg[$];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        do_start(1'b0, 16'd0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        // Now in the DONE cycle: this start is ignored.
        do_start(1'b1, 16'd3);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b done=%b in_ready=%b expected 0 0 0", busy, done, in_ready);
        end
        run_frame("b2b", 1'b0, msg, 8'h29, 8'hB1, 1'b0, 1'b1, 16'h29B1);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] msg[$];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        do_start(1'b0, 16'd9);
        for (int i = 0; i < 4; i++) send(msg[i], 1'b0);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || crc_out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b in_ready=%b crc=%h expected 0 0 0 0000",
                     busy, done, in_ready, crc_out);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = msg[4 + (i % 5)];
            cyc();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_nodone: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
        in_valid = 1'b0;
        run_frame("after_reset", 1'b0, msg, 8'h29, 8'hB1, 1'b0, 1'b1, 16'h29B1);
    endtask

    task automatic test_random();
        logic [7:0]  msg[$];
        logic [15:0] c;
        logic [15:0] sent;
        bit          o;
        bit          bad;
        for (int f = 0; f < 20; f++) begin
            msg = {};
            for (int i = 0; i < int'($urandom_range(0, 12)); i++) msg.push_back(8'($urandom));
            o    = 1'($urandom);
            bad  = 1'($urandom);
            c    = model_crc(o, msg);
            sent = bad ? (c ^ (16'd1 << $urandom_range(0, 15))) : c;
            run_frame("random", o, msg, sent[15:8], sent[7:0], 1'b1, !bad, c);
        end
    endtask

    initial begin
        RST       = 1'b1;
        start     = 1'b0;
        orient    = 1'b0;
        frame_len = 16'd0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        test_reset();
        test_vectors();
        test_abuse();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
